// File: rtl/io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : io_pkg                                                           |
// | Purpose : Shared types and constants for the serial I/O peripheral.        |
// |           Both the RX and TX state machines use the same 2-bit encoding.   |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

  localparam int DATA_BITS = 8;

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_serial_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : io_serial_port_if                                              |
// | Purpose   : Bundles the serial line and the controller-side flag           |
// |             handshake of the serial I/O peripheral.                        |
// | Signals   : rx, tx            - serial line in / out                       |
// |             INPR, FGI, fgi_clr - input byte, input flag, flag clear        |
// |             OUTR, outr_ld, FGO - output byte, load strobe, output flag     |
// |             overrun, framing_err - receive error status                    |
// | Modports  : master (controller/line side), slave (peripheral side)         |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface io_serial_port_if;
  import io_pkg::*;

  logic                 rx;
  logic                 tx;
  logic [DATA_BITS-1:0] INPR;
  logic                 FGI;
  logic                 fgi_clr;
  logic [DATA_BITS-1:0] OUTR;
  logic                 outr_ld;
  logic                 FGO;
  logic                 overrun;
  logic                 framing_err;

  modport master (
    output rx, fgi_clr, OUTR, outr_ld,
    input  tx, INPR, FGI, FGO, overrun, framing_err
  );

  modport slave (
    input  rx, fgi_clr, OUTR, outr_ld,
    output tx, INPR, FGI, FGO, overrun, framing_err
  );

endinterface : io_serial_port_if
`default_nettype wire

// File: rtl/io_serial_port_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_tx                                                        |
// | Purpose : 8N1 serialiser. Latches a byte when ready, shifts it out LSB     |
// |           first and reports readiness on the output flag.                  |
// | Ports   : clock, reset - clock and synchronous active-high reset           |
// |           outr_i       - byte to transmit                                  |
// |           outr_ld_i    - start request (ignored while busy)                |
// |           tx_o         - registered serial output, idle high               |
// |           fgo_o        - registered ready flag                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module serial_tx
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] outr_i,
  input  logic                 outr_ld_i,
  output logic                 tx_o,
  output logic                 fgo_o
);

  localparam int            TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  ser_state_e           state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 fgo_q, fgo_d;
  logic                 tick;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      fgo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      fgo_q   <= fgo_d;
    end
  end

  // tx_d is always the value for the *next* bit period, so tx stays a
  // registered output that changes exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    fgo_d   = fgo_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (outr_ld_i && fgo_q) begin
          shift_d = outr_i;
          fgo_d   = 1'b0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          fgo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_o  = tx_q;
  assign fgo_o = fgo_q;

endmodule : serial_tx
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : register                                                         |
// | Purpose : Load-only parallel register with synchronous clear on reset.     |
// | Ports   : clock, reset - clock and synchronous active-high reset           |
// |           ld_i         - load enable                                       |
// |           d_i / q_o    - data in / registered data out                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module register #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q_o <= '0;
    end else if (ld_i) begin
      q_o <= d_i;
    end
  end

endmodule : register
`default_nettype wire

// File: rtl/io_serial_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : io_serial_port                                                   |
// | Purpose : Serial I/O peripheral for the basic computer. Receives 8N1       |
// |           frames into INPR and raises FGI; transmits OUTR and reports      |
// |           readiness on FGO. Flags overrun and framing errors.              |
// | Ports   : clock, reset - clock and synchronous active-high reset           |
// |           bus (slave)  - rx/tx line, INPR/FGI/fgi_clr, OUTR/outr_ld/FGO,   |
// |                          overrun, framing_err                              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module io_serial_port
  import io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clock,
  input  logic            reset,
  io_serial_port_if.slave bus
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST      = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  // Two-flop synchroniser; both stages reset to the idle level so that
  // leaving reset never looks like a start bit.
  logic rx_meta_q, rxs_q;

  ser_state_e           state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fgi_q, fgi_d;
  logic                 ovr_q, ovr_d;
  logic                 fe_q, fe_d;
  logic                 stop_good, stop_bad;
  logic                 inpr_ld;
  logic [DATA_BITS-1:0] inpr;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      fgi_q     <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      fgi_q     <= fgi_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
    end
  end

  // Receive state machine: start bit checked at its midpoint, then every
  // following bit sampled one full bit period later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          stop_good = rxs_q;
          stop_bad  = !rxs_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear arriving with a good stop bit is applied first, so the new byte
  // is accepted rather than counted as lost.
  always_comb begin
    inpr_ld = stop_good && (!fgi_q || bus.fgi_clr);
    fgi_d   = fgi_q;
    ovr_d   = ovr_q;
    fe_d    = stop_bad;
    if (bus.fgi_clr) begin
      fgi_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (stop_good) begin
      fgi_d = 1'b1;
      if (fgi_q && !bus.fgi_clr) begin
        ovr_d = 1'b1;
      end
    end
  end

  register #(
    .WIDTH (DATA_BITS)
  ) u_inpr (
    .clock (clock),
    .reset (reset),
    .ld_i  (inpr_ld),
    .d_i   (shift_q),
    .q_o   (inpr)
  );

  serial_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clock     (clock),
    .reset     (reset),
    .outr_i    (bus.OUTR),
    .outr_ld_i (bus.outr_ld),
    .tx_o      (bus.tx),
    .fgo_o     (bus.FGO)
  );

  assign bus.INPR        = inpr;
  assign bus.FGI         = fgi_q;
  assign bus.overrun     = ovr_q;
  assign bus.framing_err = fe_q;

endmodule : io_serial_port
`default_nettype wire

// File: tb/tb_io_serial_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_io_serial_port                                                |
// | Purpose : Self-checking bench for io_serial_port at 4 clocks per bit.      |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_io_serial_port;

  localparam int CPB = 4;

  logic clock;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   fe_count = 0;

  logic [7:0] rxq[$];
  logic       txq[$];

  io_serial_port_if bus ();

  io_serial_port #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.framing_err === 1'b1) fe_count <= fe_count + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; called on a falling edge, returns on a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clock);
  endtask

  // FGI must still be low when the frame ends and rise on the very next edge.
  task automatic expect_rx(input string tag);
    logic [7:0] e;
    chk({tag, "_fgi_early"}, bus.FGI, 1'b0);
    @(posedge clock); #1;
    chk({tag, "_fgi"}, bus.FGI, 1'b1);
    chk({tag, "_sb_nonempty"}, rxq.size() != 0, 1'b1);
    if (rxq.size() != 0) begin
      e = rxq.pop_front();
      chk({tag, "_inpr"}, bus.INPR, e);
    end
    @(negedge clock);
  endtask

  task automatic pulse_clr();
    bus.fgi_clr = 1'b1;
    @(negedge clock);
    bus.fgi_clr = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    txq.push_back(1'b0);
    for (int i = 0; i < 8; i++) txq.push_back(b[i]);
    txq.push_back(1'b1);
  endtask

  // Entered #1 after the edge that accepted outr_ld; checks 40 cycles.
  task automatic run_tx(input logic inject);
    logic cur;
    cur = 1'b1;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c % CPB == 0) begin
        chk("tx_sb_nonempty", txq.size() != 0, 1'b1);
        if (txq.size() != 0) cur = txq.pop_front();
      end
      chk("tx_bit", bus.tx, cur);
      chk("fgo_busy", bus.FGO, 1'b0);
      if (inject && c == 15) begin
        bus.OUTR    = 8'hFF;
        bus.outr_ld = 1'b1;
      end
      if (inject && c == 16) bus.outr_ld = 1'b0;
      @(posedge clock); #1;
    end
    chk("fgo_ready", bus.FGO, 1'b1);
    chk("tx_idle", bus.tx, 1'b1);
  endtask

  initial begin
    int fe_before;
    reset       = 1'b1;
    bus.rx      = 1'b1;
    bus.fgi_clr = 1'b0;
    bus.OUTR    = 8'h00;
    bus.outr_ld = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // reset state
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_fgo", bus.FGO, 1'b1);
    chk("rst_inpr", bus.INPR, 8'h00);
    chk("rst_fgi", bus.FGI, 1'b0);
    chk("rst_ovr", bus.overrun, 1'b0);
    chk("rst_fe", bus.framing_err, 1'b0);
    repeat (2) @(negedge clock);

    // 1: 0xA5
    rxq.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    expect_rx("s1");
    chk("s1_no_fe", fe_count, 0);
    repeat (2) @(negedge clock);

    // 2: clear then 0x3C
    pulse_clr();
    chk("s2_fgi_clr", bus.FGI, 1'b0);
    rxq.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    expect_rx("s2");
    repeat (2) @(negedge clock);

    // 3: 0x11 then 0x22 without clear
    pulse_clr();
    rxq.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    expect_rx("s3a");
    chk("s3a_ovr", bus.overrun, 1'b0);
    send_frame(8'h22, 1'b1);
    @(posedge clock); #1;
    chk("s3_ovr", bus.overrun, 1'b1);
    chk("s3_inpr", bus.INPR, 8'h11);
    chk("s3_fgi", bus.FGI, 1'b1);
    @(negedge clock);
    pulse_clr();
    chk("s3_clr_fgi", bus.FGI, 1'b0);
    chk("s3_clr_ovr", bus.overrun, 1'b0);
    repeat (2) @(negedge clock);

    // 4: bad stop bit, then a 1-cycle glitch
    fe_before = fe_count;
    send_frame(8'h55, 1'b0);
    bus.rx = 1'b1;
    @(posedge clock); #1;
    chk("s4_fe_pulse", bus.framing_err, 1'b1);
    @(posedge clock); #1;
    chk("s4_fe_end", bus.framing_err, 1'b0);
    repeat (10) @(negedge clock);
    chk("s4_fe_once", fe_count, fe_before + 1);
    chk("s4_inpr", bus.INPR, 8'h11);
    chk("s4_fgi", bus.FGI, 1'b0);
    bus.rx = 1'b0;
    @(negedge clock);
    bus.rx = 1'b1;
    repeat (60) @(negedge clock);
    chk("s4_glitch_fgi", bus.FGI, 1'b0);
    chk("s4_glitch_fe", fe_count, fe_before + 1);
    chk("s4_glitch_inpr", bus.INPR, 8'h11);

    // 5: transmit 0x81, ignored mid-frame load, back-to-back 0x3C
    bus.OUTR    = 8'h81;
    bus.outr_ld = 1'b1;
    push_tx(8'h81);
    @(posedge clock); #1;
    bus.outr_ld = 1'b0;
    run_tx(1'b1);
    bus.OUTR    = 8'h3C;
    bus.outr_ld = 1'b1;
    push_tx(8'h3C);
    @(posedge clock); #1;
    bus.outr_ld = 1'b0;
    run_tx(1'b0);
    @(negedge clock);

    // 6: flags up, then reset mid-RX and mid-TX, then clean 0x7E
    rxq.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    expect_rx("s6a");
    send_frame(8'h99, 1'b1);
    repeat (2) @(negedge clock);
    chk("s6_ovr_set", bus.overrun, 1'b1);
    bus.rx      = 1'b0;
    bus.OUTR    = 8'h5A;
    bus.outr_ld = 1'b1;
    @(negedge clock);
    bus.outr_ld = 1'b0;
    repeat (10) @(negedge clock);
    chk("s6_tx_busy", bus.FGO, 1'b0);
    reset  = 1'b1;
    bus.rx = 1'b1;
    @(posedge clock); #1;
    chk("s6_rst_tx", bus.tx, 1'b1);
    chk("s6_rst_fgo", bus.FGO, 1'b1);
    chk("s6_rst_fgi", bus.FGI, 1'b0);
    chk("s6_rst_ovr", bus.overrun, 1'b0);
    chk("s6_rst_inpr", bus.INPR, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    rxq.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    expect_rx("s6b");
    chk("s6_ovr_after", bus.overrun, 1'b0);
    chk("s6_fgo_after", bus.FGO, 1'b1);
    chk("s6_tx_after", bus.tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_io_serial_port
`default_nettype wire
